// File: rtl/lvt_read_select.sv
// lvt_read_select: live-value table that merges two 4R1W replicated banks into
// a coherent 2W4R memory view. Bank 0 backs write port 0 and bank 1 backs
// write port 1. A 1-bit-per-address table records which bank holds the live
// value, and each read port muxes the matching bank's registered read data.
//
// Optional feature (macro LVT_WR_BYPASS_EN): a same-cycle write-to-read
// bypass that returns the new write data instead of the banks' old data.
// Without the macro, a colliding read returns the old live value, as the
// banks do.

module lvt_read_lane #(
    parameter int DWIDTH = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              live,
`ifdef LVT_WR_BYPASS_EN
    input  logic              byp_hit,
    input  logic [DWIDTH-1:0] byp_data,
`endif
    input  logic [DWIDTH-1:0] b0_dout,
    input  logic [DWIDTH-1:0] b1_dout,
    output logic [DWIDTH-1:0] dout,
    output logic              vld
);
    logic sel;
`ifdef LVT_WR_BYPASS_EN
    logic              byp;
    logic [DWIDTH-1:0] byp_q;

    // Capture the bypass flag and write data alongside the bank select.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            byp   <= 1'b0;
            byp_q <= '0;
        end else begin
            byp   <= byp_hit;
            byp_q <= byp_data;
        end
    end
`endif

    // Register the live-bank select and the valid bit. Latency is one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld <= 1'b0;
            sel <= 1'b0;
        end else begin
            vld <= req;
            sel <= live;
        end
    end

    // Pick the live bank's data, or force zero when the slot is not valid.
    always_comb begin
        dout = '0;
        if (vld) begin
`ifdef LVT_WR_BYPASS_EN
            if (byp) dout = byp_q;
            else     dout = sel ? b1_dout : b0_dout;
`else
            dout = sel ? b1_dout : b0_dout;
`endif
        end
    end
endmodule

module lvt_read_select #(
    parameter int BLOCLSIZE = 11,
    parameter int DWIDTH    = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [BLOCLSIZE:0]   w_addr_0,
    input  logic [DWIDTH-1:0]    w_din_0,
    input  logic                 w_enb_0,
    input  logic [BLOCLSIZE:0]   w_addr_1,
    input  logic [DWIDTH-1:0]    w_din_1,
    input  logic                 w_enb_1,
    output logic                 bank0_w_enb,
    output logic                 bank1_w_enb,
    input  logic                 r_req_1,
    input  logic                 r_req_2,
    input  logic                 r_req_3,
    input  logic                 r_req_4,
    input  logic [BLOCLSIZE:0]   r_addr_1,
    input  logic [BLOCLSIZE:0]   r_addr_2,
    input  logic [BLOCLSIZE:0]   r_addr_3,
    input  logic [BLOCLSIZE:0]   r_addr_4,
    input  logic [DWIDTH-1:0]    b0_dout_1,
    input  logic [DWIDTH-1:0]    b0_dout_2,
    input  logic [DWIDTH-1:0]    b0_dout_3,
    input  logic [DWIDTH-1:0]    b0_dout_4,
    input  logic [DWIDTH-1:0]    b1_dout_1,
    input  logic [DWIDTH-1:0]    b1_dout_2,
    input  logic [DWIDTH-1:0]    b1_dout_3,
    input  logic [DWIDTH-1:0]    b1_dout_4,
    output logic [DWIDTH-1:0]    r_dout_1,
    output logic [DWIDTH-1:0]    r_dout_2,
    output logic [DWIDTH-1:0]    r_dout_3,
    output logic [DWIDTH-1:0]    r_dout_4,
    output logic                 r_vld_1,
    output logic                 r_vld_2,
    output logic                 r_vld_3,
    output logic                 r_vld_4
);
    localparam int NUM_LANES = 4;
    localparam int AW        = BLOCLSIZE + 1;
    localparam int DEPTH     = 1 << AW;

    logic [DEPTH-1:0]                   lvt;
    logic [NUM_LANES-1:0]               req, live, vld;
    logic [NUM_LANES-1:0][AW-1:0]       addr;
    logic [NUM_LANES-1:0][DWIDTH-1:0]   b0, b1, dout;

    assign req  = {r_req_4, r_req_3, r_req_2, r_req_1};
    assign addr = {r_addr_4, r_addr_3, r_addr_2, r_addr_1};
    assign b0   = {b0_dout_4, b0_dout_3, b0_dout_2, b0_dout_1};
    assign b1   = {b1_dout_4, b1_dout_3, b1_dout_2, b1_dout_1};

    assign {r_dout_4, r_dout_3, r_dout_2, r_dout_1} = dout;
    assign {r_vld_4, r_vld_3, r_vld_2, r_vld_1}     = vld;

    // Block bank writes while reset is held so the banks and the table agree.
    assign bank0_w_enb = w_enb_0 & ~rst;
    assign bank1_w_enb = w_enb_1 & ~rst;

    // Record which bank owns each address. Port 1 is applied last, so it
    // wins a same-address collision; bank 0's copy is then dead.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lvt <= '0;
        end else begin
            if (w_enb_0) lvt[w_addr_0] <= 1'b0;
            if (w_enb_1) lvt[w_addr_1] <= 1'b1;
        end
    end

    // Look up the table before this edge's update. This matches the banks'
    // old-data behaviour on a read/write collision.
    always_comb begin
        live = '0;
        for (int n = 0; n < NUM_LANES; n++) live[n] = lvt[addr[n]];
    end

`ifdef LVT_WR_BYPASS_EN
    logic [NUM_LANES-1:0]             byp_hit;
    logic [NUM_LANES-1:0][DWIDTH-1:0] byp_data;

    // Detect a read that hits a same-cycle write. Port 1 data has priority.
    always_comb begin
        byp_hit  = '0;
        byp_data = '0;
        for (int n = 0; n < NUM_LANES; n++) begin
            if (req[n]) begin
                if (w_enb_1 && addr[n] == w_addr_1) begin
                    byp_hit[n]  = 1'b1;
                    byp_data[n] = w_din_1;
                end else if (w_enb_0 && addr[n] == w_addr_0) begin
                    byp_hit[n]  = 1'b1;
                    byp_data[n] = w_din_0;
                end
            end
        end
    end
`else
    // Write data only reaches the banks externally. It is not used here.
    logic unused_wdata;
    assign unused_wdata = ^{w_din_0, w_din_1};
`endif

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        lvt_read_lane #(.DWIDTH(DWIDTH)) u_lane (
            .clk      (clk),
            .rst      (rst),
            .req      (req[g]),
            .live     (live[g]),
`ifdef LVT_WR_BYPASS_EN
            .byp_hit  (byp_hit[g]),
            .byp_data (byp_data[g]),
`endif
            .b0_dout  (b0[g]),
            .b1_dout  (b1[g]),
            .dout     (dout[g]),
            .vld      (vld[g])
        );
    end
endmodule

// File: tb/tb_lvt_read_select.sv
// Directed testbench for lvt_read_select. The bench drives the bank read-data
// inputs by hand, one cycle after each read address, and checks the selected
// output against hand-computed values. Build with +define+LVT_WR_BYPASS_EN
// to check the bypass variant.

module tb_lvt_read_select;
`ifdef LVT_WR_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] w_addr_0, w_addr_1;
    logic [31:0] w_din_0, w_din_1;
    logic        w_enb_0, w_enb_1;
    logic        bank0_w_enb, bank1_w_enb;
    logic        r_req_1, r_req_2, r_req_3, r_req_4;
    logic [11:0] r_addr_1, r_addr_2, r_addr_3, r_addr_4;
    logic [31:0] b0_dout_1, b0_dout_2, b0_dout_3, b0_dout_4;
    logic [31:0] b1_dout_1, b1_dout_2, b1_dout_3, b1_dout_4;
    logic [31:0] r_dout_1, r_dout_2, r_dout_3, r_dout_4;
    logic        r_vld_1, r_vld_2, r_vld_3, r_vld_4;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    lvt_read_select #(.BLOCLSIZE(11), .DWIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .w_addr_0(w_addr_0), .w_din_0(w_din_0), .w_enb_0(w_enb_0),
        .w_addr_1(w_addr_1), .w_din_1(w_din_1), .w_enb_1(w_enb_1),
        .bank0_w_enb(bank0_w_enb), .bank1_w_enb(bank1_w_enb),
        .r_req_1(r_req_1), .r_req_2(r_req_2), .r_req_3(r_req_3), .r_req_4(r_req_4),
        .r_addr_1(r_addr_1), .r_addr_2(r_addr_2), .r_addr_3(r_addr_3), .r_addr_4(r_addr_4),
        .b0_dout_1(b0_dout_1), .b0_dout_2(b0_dout_2), .b0_dout_3(b0_dout_3), .b0_dout_4(b0_dout_4),
        .b1_dout_1(b1_dout_1), .b1_dout_2(b1_dout_2), .b1_dout_3(b1_dout_3), .b1_dout_4(b1_dout_4),
        .r_dout_1(r_dout_1), .r_dout_2(r_dout_2), .r_dout_3(r_dout_3), .r_dout_4(r_dout_4),
        .r_vld_1(r_vld_1), .r_vld_2(r_vld_2), .r_vld_3(r_vld_3), .r_vld_4(r_vld_4)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        w_enb_0 = 1'b0; w_enb_1 = 1'b0;
        r_req_1 = 1'b0; r_req_2 = 1'b0; r_req_3 = 1'b0; r_req_4 = 1'b0;
    endtask

    task automatic set_banks(input logic [31:0] v0, input logic [31:0] v1);
        b0_dout_1 = v0; b0_dout_2 = v0; b0_dout_3 = v0; b0_dout_4 = v0;
        b1_dout_1 = v1; b1_dout_2 = v1; b1_dout_3 = v1; b1_dout_4 = v1;
    endtask

    initial begin
        rst = 1'b1;
        idle();
        w_addr_0 = '0; w_addr_1 = '0; w_din_0 = '0; w_din_1 = '0;
        r_addr_1 = '0; r_addr_2 = '0; r_addr_3 = '0; r_addr_4 = '0;
        set_banks(32'hB0B0_B0B0, 32'hB1B1_B1B1);

        // Reset state. Write enables must be blocked while reset is held.
        r_req_1 = 1'b1; w_enb_0 = 1'b1; w_enb_1 = 1'b1;
        step(); step();
        check("rst_vld1", {31'b0, r_vld_1}, 32'h0);
        check("rst_dout1", r_dout_1, 32'h0);
        check("rst_dout4", r_dout_4, 32'h0);
        check("rst_b0enb", {31'b0, bank0_w_enb}, 32'h0);
        check("rst_b1enb", {31'b0, bank1_w_enb}, 32'h0);
        idle();
        rst = 1'b0;

        // Write gating is combinational once reset is released.
        w_enb_0 = 1'b1; #1;
        check("gate_b0enb", {31'b0, bank0_w_enb}, 32'h1);
        check("gate_b1enb", {31'b0, bank1_w_enb}, 32'h0);
        w_enb_0 = 1'b0; w_enb_1 = 1'b1; #1;
        check("gate_b1enb_on", {31'b0, bank1_w_enb}, 32'h1);
        w_enb_1 = 1'b0;

        // A read of a never-written address selects bank 0.
        r_req_1 = 1'b1; r_addr_1 = 12'h005;
        step();
        idle();
        set_banks(32'h0000_0000, 32'hDEAD_BEEF);
        #1;
        check("rd005_vld", {31'b0, r_vld_1}, 32'h1);
        check("rd005_dout", r_dout_1, 32'h0000_0000);
        step();
        check("rd005_vld_drop", {31'b0, r_vld_1}, 32'h0);

        // A port 1 write, then a read of that address on all four ports.
        w_enb_1 = 1'b1; w_addr_1 = 12'h010; w_din_1 = 32'h1111_1111;
        step();
        idle();
        r_req_1 = 1'b1; r_req_2 = 1'b1; r_req_3 = 1'b1; r_req_4 = 1'b1;
        r_addr_1 = 12'h010; r_addr_2 = 12'h010; r_addr_3 = 12'h010; r_addr_4 = 12'h010;
        step();
        idle();
        set_banks(32'h0BAD_0BAD, 32'h1111_1111);
        #1;
        check("rd010_p1", r_dout_1, 32'h1111_1111);
        check("rd010_p2", r_dout_2, 32'h1111_1111);
        check("rd010_p3", r_dout_3, 32'h1111_1111);
        check("rd010_p4", r_dout_4, 32'h1111_1111);
        check("rd010_vld", {28'b0, r_vld_4, r_vld_3, r_vld_2, r_vld_1}, 32'hF);
        step();

        // Both ports write the same address. Port 1 owns it afterwards.
        w_enb_0 = 1'b1; w_addr_0 = 12'h020; w_din_0 = 32'hAAAA_AAAA;
        w_enb_1 = 1'b1; w_addr_1 = 12'h020; w_din_1 = 32'h5555_5555;
        step();
        idle();
        r_req_2 = 1'b1; r_addr_2 = 12'h020;
        step();
        idle();
        set_banks(32'hAAAA_AAAA, 32'h5555_5555);
        #1;
        check("coll020", r_dout_2, 32'h5555_5555);
        step();

        // A same-cycle write and read of one address.
        w_enb_0 = 1'b1; w_addr_0 = 12'h030; w_din_0 = 32'h0000_0030;
        r_req_3 = 1'b1; r_addr_3 = 12'h030;
        step();
        idle();
        set_banks(32'h0000_0000, 32'h3333_3333);
        #1;
        check("wr_rd030", r_dout_3, BYP ? 32'h0000_0030 : 32'h0000_0000);
        step();

        // Both ports write and a read hits them. Port 1 data wins the bypass.
        w_enb_0 = 1'b1; w_addr_0 = 12'h050; w_din_0 = 32'h0000_5000;
        w_enb_1 = 1'b1; w_addr_1 = 12'h050; w_din_1 = 32'h0000_5001;
        r_req_1 = 1'b1; r_addr_1 = 12'h050;
        step();
        idle();
        set_banks(32'h0000_0B00, 32'h0000_0B01);
        #1;
        check("wr2_rd050", r_dout_1, BYP ? 32'h0000_5001 : 32'h0000_0B00);
        step();

        // Reset in the middle of traffic. The table returns to bank 0.
        w_enb_1 = 1'b1; w_addr_1 = 12'h040; w_din_1 = 32'h4040_4040;
        step();
        idle();
        r_req_1 = 1'b1; r_addr_1 = 12'h040;
        step();
        set_banks(32'h0000_0B00, 32'h4040_4040);
        #1;
        check("pre_rst040", r_dout_1, 32'h4040_4040);
        rst = 1'b1;
        #1;
        check("mid_rst_vld", {31'b0, r_vld_1}, 32'h0);
        check("mid_rst_dout", r_dout_1, 32'h0);
        step();
        rst = 1'b0;
        step();
        idle();
        set_banks(32'h0000_0B00, 32'h4040_4040);
        #1;
        check("post_rst040", r_dout_1, 32'h0000_0B00);
        step();

        // Alternate port 0 and port 1 writes to 0xFFF while reading it every cycle.
        set_banks(32'hB0B0_B0B0, 32'hB1B1_B1B1);
        for (int k = 0; k < 6; k++) begin
            logic [31:0] exp;
            w_enb_0 = (k % 2 == 0); w_addr_0 = 12'hFFF; w_din_0 = 32'h100 + k;
            w_enb_1 = (k % 2 == 1); w_addr_1 = 12'hFFF; w_din_1 = 32'h200 + k;
            r_req_4 = 1'b1; r_addr_4 = 12'hFFF;
            step();
            if (BYP)                exp = (k % 2 == 0) ? 32'h100 + k : 32'h200 + k;
            else if (k == 0)        exp = 32'hB0B0_B0B0;
            else if (k % 2 == 0)    exp = 32'hB1B1_B1B1;
            else                    exp = 32'hB0B0_B0B0;
            check($sformatf("alt_fff_%0d", k), r_dout_4, exp);
            check($sformatf("alt_vld_%0d", k), {31'b0, r_vld_4}, 32'h1);
        end
        idle();
        step();
        check("end_vld4", {31'b0, r_vld_4}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
